// File: rtl/iob_mem_arbiter_if.sv
// iob_mem_arbiter_if: IOb native bundle for the i/d requester ports and the shared memory port
// slave  : arbiter view (requests in from i/d, request out to memory, responses routed back)
// master : environment view (CPU buses drive requests, memory drives responses)
interface iob_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_avalid;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_rvalid;
  logic              i_ready;
  logic              d_avalid;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W/8-1:0] d_wstrb;
  logic [DATA_W-1:0] d_rdata;
  logic              d_rvalid;
  logic              d_ready;
  logic              m_avalid;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W/8-1:0] m_wstrb;
  logic [DATA_W-1:0] m_rdata;
  logic              m_rvalid;
  logic              m_ready;
  modport slave (
    input  i_avalid, i_addr, d_avalid, d_addr, d_wdata, d_wstrb, m_rdata, m_rvalid, m_ready,
    output i_rdata, i_rvalid, i_ready, d_rdata, d_rvalid, d_ready, m_avalid, m_addr, m_wdata, m_wstrb
  );
  modport master (
    output i_avalid, i_addr, d_avalid, d_addr, d_wdata, d_wstrb, m_rdata, m_rvalid, m_ready,
    input  i_rdata, i_rvalid, i_ready, d_rdata, d_rvalid, d_ready, m_avalid, m_addr, m_wdata, m_wstrb
  );
endinterface

// File: rtl/iob_mem_arbiter.sv
// iob_mem_arbiter: shares one IOb memory port between instruction (i) and data (d) requesters
// clk_i/rst_i : clock, synchronous active-high reset
// cke_i       : clock enable, all registers hold while low
// bus         : i/d request ports and shared m port (iob_mem_arbiter_if.slave)
// busy_o      : grant held or read outstanding
// IOB_ARB_RR_EN: when defined, simultaneous requests alternate instead of d > i priority
module iob_mem_arbiter (
  input  logic clk_i,
  input  logic rst_i,
  input  logic cke_i,
  iob_mem_arbiter_if.slave bus,
  output logic busy_o
);
  typedef enum logic [1:0] {IDLE, HOLD, WAIT_R} state_t;
  state_t state_q, state_d;
  logic owner_q, owner_d;
  logic sel, pick, req, acc, rd;
`ifdef IOB_ARB_RR_EN
  logic last_q, last_d;
  assign pick = (bus.i_avalid & bus.d_avalid) ? ~last_q : bus.d_avalid;
  assign last_d = acc ? sel : last_q;
`else
  assign pick = bus.d_avalid;
`endif
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
    end else if (cke_i) begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end
`ifdef IOB_ARB_RR_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) last_q <= 1'b0;
    else if (cke_i) last_q <= last_d;
  end
`endif
  // sel: 1 = d port; in HOLD the grant stays with the owner, in WAIT_R nothing is requested
  always_comb begin
    sel = state_q == IDLE ? pick : owner_q;
    req = state_q == IDLE ? (bus.i_avalid | bus.d_avalid) :
          state_q == HOLD ? (owner_q ? bus.d_avalid : bus.i_avalid) : 1'b0;
    acc = req & bus.m_ready;
    rd = ~sel | (bus.d_wstrb == '0);
    state_d = state_q == WAIT_R ? (bus.m_rvalid ? IDLE : WAIT_R) :
              ~req ? IDLE : acc ? (rd ? WAIT_R : IDLE) : HOLD;
    owner_d = req ? sel : owner_q;
    bus.m_avalid = req;
    bus.m_addr = req ? (sel ? bus.d_addr : bus.i_addr) : '0;
    bus.m_wdata = (req & sel) ? bus.d_wdata : '0;
    bus.m_wstrb = (req & sel) ? bus.d_wstrb : '0;
    bus.i_ready = acc & ~sel;
    bus.d_ready = acc & sel;
    bus.i_rvalid = state_q == WAIT_R & ~owner_q & bus.m_rvalid;
    bus.d_rvalid = state_q == WAIT_R & owner_q & bus.m_rvalid;
    bus.i_rdata = bus.m_rdata;
    bus.d_rdata = bus.m_rdata;
    busy_o = state_q != IDLE;
  end
endmodule
